ret_addr_stack: RTL and testbench

Hardware return-address stack for CALL/RET flow control.
- On CALL, pushes the return address (pc + 1) and redirects the program counter to the call target.
- On RET, pops the most recent return address and redirects the program counter to it.
- Sits beside the conditional-jump logic in the program-flow unit and produces the redirect PC that the fetch stage consumes.
- Registered, with a fault state that blocks further stack traffic after an overflow, underflow or protocol error.

---
 rtl/ret_addr_stack_pkg.sv | 27 ++
 rtl/ret_addr_stack_lifo.sv | 85 ++++++++
 rtl/ret_addr_stack.sv | 159 +++++++++++++++
 tb/tb_ret_addr_stack.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ret_addr_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ret_addr_stack_pkg
// Description : Shared flow-control definitions for the return-address stack:
//               default instruction address width, RUN/FAULT state encoding
//               and the count-width helper used by the top and the LIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ret_addr_stack_pkg;

    // Default instruction address width of the program-flow unit.
    localparam int c_ras_addr_w = 20;

    // Controller states. FAULT blocks all stack traffic until err_clr.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ras_state_t;

    // Width needed to hold an occupancy value in the range 0..depth
    // inclusive (a full stack needs one more bit than the pointer).
    function automatic int ras_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : ret_addr_stack_pkg
`default_nettype wire

// File: rtl/ret_addr_stack_lifo.sv
`default_nettype none
// ============================================================================
// Module      : ras_lifo
// Description : Storage array and occupancy counter for the return-address
//               stack. Write is synchronous at stack[count] on push; the top
//               entry stack[count-1] is read combinationally so a pop returns
//               data committed at an earlier edge.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push, push_data     - write push_data at the current top
//               pop                 - discard the current top entry
//               top_data            - stack[count-1], meaningful when !empty
//               count, full, empty  - occupancy and its decoded flags
// Revision    : 1.0 - initial release
// ============================================================================
module ras_lifo
    import ret_addr_stack_pkg::*;
#(
    parameter int ADDR_W  = c_ras_addr_w,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = ras_count_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_data,
    input  logic               pop,
    output logic [ADDR_W-1:0]  top_data,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] c_depth   = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] c_cnt_one = COUNT_W'(1);
    localparam logic [PTR_W-1:0]   c_ptr_one = PTR_W'(1);

    // Storage is deliberately not reset: no entry is readable while empty.
    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic [COUNT_W-1:0] r_count;

    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Guard here as well so the LIFO can never corrupt itself, whatever
    // the caller does.
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop  && !w_empty;

    // DEPTH is a power of two, so the low count bits address the slot
    // above the top. When full the low bits wrap to 0, but no push is
    // allowed then, and the read pointer (0 - 1) correctly lands on DEPTH-1.
    assign w_wr_ptr = r_count[PTR_W-1:0];
    assign w_rd_ptr = w_wr_ptr - c_ptr_one;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_cnt_one;
        end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - c_cnt_one;
        end
    end

    assign top_data = r_mem[w_rd_ptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule : ras_lifo
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_addr_stack
// Description : Hardware return-address stack for CALL/RET. CALL pushes
//               pc+1 and redirects fetch to call_target; RET pops the most
//               recent return address and redirects fetch to it. Overflow,
//               underflow or simultaneous CALL+RET set a sticky flag and
//               park the block in FAULT until err_clr.
// Ports       : clk, rst_n                - clock, async active-low reset
//               pc, call_valid, call_target, ret_valid - requests
//               err_clr                   - clear sticky flags / leave FAULT
//               new_pc, new_pc_valid      - registered one-cycle redirect
//               count, full, empty        - stack occupancy
//               overflow_err, underflow_err, proto_err, fault - status
// Revision    : 1.0 - initial release
// ============================================================================
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int ADDR_W = c_ras_addr_w,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             pc,
    input  logic                          call_valid,
    input  logic [ADDR_W-1:0]             call_target,
    input  logic                          ret_valid,
    input  logic                          err_clr,
    output logic [ADDR_W-1:0]             new_pc,
    output logic                          new_pc_valid,
    output logic [ras_count_w(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow_err,
    output logic                          underflow_err,
    output logic                          proto_err,
    output logic                          fault
);

    localparam int                COUNT_W    = ras_count_w(DEPTH);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    ras_state_t         r_state;
    logic [ADDR_W-1:0]  r_new_pc;
    logic               r_new_pc_valid;
    logic               r_overflow_err;
    logic               r_underflow_err;
    logic               r_proto_err;

    logic               w_run;
    logic               w_call_only;
    logic               w_ret_only;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_ret_addr;
    logic [ADDR_W-1:0]  w_top_data;
    logic [COUNT_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;

    assign w_run       = (r_state == ST_RUN);
    assign w_call_only = call_valid && !ret_valid;
    assign w_ret_only  = ret_valid  && !call_valid;

    // Stack traffic only happens in RUN for a lone, legal request; a
    // simultaneous CALL+RET moves nothing.
    assign w_push = w_run && w_call_only && !w_full;
    assign w_pop  = w_run && w_ret_only  && !w_empty;

    // Return address wraps naturally at the address width.
    assign w_ret_addr = pc + c_addr_one;

    ras_lifo #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_ret_addr),
        .pop       (w_pop),
        .top_data  (w_top_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Controller, sticky flags and redirect registers in one process.
    // The strobe defaults low every cycle so it lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RUN;
            r_new_pc        <= '0;
            r_new_pc_valid  <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_new_pc_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    // Clearing first lets a same-cycle error re-set a flag.
                    if (err_clr) begin
                        r_overflow_err  <= 1'b0;
                        r_underflow_err <= 1'b0;
                        r_proto_err     <= 1'b0;
                    end
                    // The protocol check outranks full/empty.
                    if (call_valid && ret_valid) begin
                        r_proto_err <= 1'b1;
                        r_state     <= ST_FAULT;
                    end else if (call_valid) begin
                        if (w_full) begin
                            r_overflow_err <= 1'b1;
                            r_state        <= ST_FAULT;
                        end else begin
                            r_new_pc       <= call_target;
                            r_new_pc_valid <= 1'b1;
                        end
                    end else if (ret_valid) begin
                        if (w_empty) begin
                            r_underflow_err <= 1'b1;
                            r_state         <= ST_FAULT;
                        end else begin
                            r_new_pc       <= w_top_data;
                            r_new_pc_valid <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Requests are ignored; stack contents are kept.
                    if (err_clr) begin
                        r_overflow_err  <= 1'b0;
                        r_underflow_err <= 1'b0;
                        r_proto_err     <= 1'b0;
                        r_state         <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign new_pc        = r_new_pc;
    assign new_pc_valid  = r_new_pc_valid;
    assign count         = w_count;
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;
    assign proto_err     = r_proto_err;
    assign fault         = (r_state == ST_FAULT);

endmodule : ret_addr_stack
`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ret_addr_stack
// Description : Self-checking bench for ret_addr_stack. A queue-based model
//               tracks the expected stack, redirect and status; a compare
//               process checks every output on each falling edge, and the
//               directed sequence adds hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ret_addr_stack;

    localparam int ADDR_W  = 20;
    localparam int DEPTH   = 16;
    localparam int COUNT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [ADDR_W-1:0]  pc = '0;
    logic               call_valid = 1'b0;
    logic [ADDR_W-1:0]  call_target = '0;
    logic               ret_valid = 1'b0;
    logic               err_clr = 1'b0;
    logic [ADDR_W-1:0]  new_pc;
    logic               new_pc_valid;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic               empty;
    logic               overflow_err;
    logic               underflow_err;
    logic               proto_err;
    logic               fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ret_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .call_valid    (call_valid),
        .call_target   (call_target),
        .ret_valid     (ret_valid),
        .err_clr       (err_clr),
        .new_pc        (new_pc),
        .new_pc_valid  (new_pc_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .proto_err     (proto_err),
        .fault         (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_stack[$];
    bit m_fault, m_ovf, m_unf, m_proto, m_valid;
    int m_new_pc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stack.delete();
            m_fault = 0; m_ovf = 0; m_unf = 0; m_proto = 0;
            m_valid = 0; m_new_pc = 0;
        end else begin
            m_valid = 0;
            if (m_fault) begin
                if (err_clr) begin
                    m_ovf = 0; m_unf = 0; m_proto = 0; m_fault = 0;
                end
            end else begin
                if (err_clr) begin
                    m_ovf = 0; m_unf = 0; m_proto = 0;
                end
                if (call_valid && ret_valid) begin
                    m_proto = 1; m_fault = 1;
                end else if (call_valid) begin
                    if (m_stack.size() == DEPTH) begin
                        m_ovf = 1; m_fault = 1;
                    end else begin
                        m_stack.push_back((int'(pc) + 1) % (1 << ADDR_W));
                        m_new_pc = int'(call_target);
                        m_valid  = 1;
                    end
                end else if (ret_valid) begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1; m_fault = 1;
                    end else begin
                        m_new_pc = m_stack.pop_back();
                        m_valid  = 1;
                    end
                end
            end
        end
    end

    // Outputs are registered; inputs change on the falling edge, so
    // sampling here sees settled post-edge values.
    always @(negedge clk) begin
        if (rst_n) begin
            check("new_pc",        32'(new_pc),        32'(m_new_pc));
            check("new_pc_valid",  32'(new_pc_valid),  32'(m_valid));
            check("count",         32'(count),         32'(m_stack.size()));
            check("full",          32'(full),          32'(m_stack.size() == DEPTH));
            check("empty",         32'(empty),         32'(m_stack.size() == 0));
            check("overflow_err",  32'(overflow_err),  32'(m_ovf));
            check("underflow_err", 32'(underflow_err), 32'(m_unf));
            check("proto_err",     32'(proto_err),     32'(m_proto));
            check("fault",         32'(fault),         32'(m_fault));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; applies one request for one rising edge and
    // returns at the next falling edge with the result visible.
    task automatic op(input bit c, input bit r, input bit clr,
                      input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] t);
        call_valid  = c;
        ret_valid   = r;
        err_clr     = clr;
        pc          = p;
        call_target = t;
        @(negedge clk);
        call_valid = 1'b0;
        ret_valid  = 1'b0;
        err_clr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(new_pc_valid), 32'd0);
        check("rst_new_pc", 32'(new_pc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic CALL / RET
        op(1, 0, 0, 20'h00100, 20'h02000);
        check("call_new_pc", 32'(new_pc), 32'h02000);
        check("call_valid_strobe", 32'(new_pc_valid), 32'd1);
        check("call_count", 32'(count), 32'd1);
        op(0, 1, 0, '0, '0);
        check("ret_new_pc", 32'(new_pc), 32'h00101);
        check("ret_count", 32'(count), 32'd0);
        check("ret_empty", 32'(empty), 32'd1);
        @(negedge clk);
        check("strobe_one_cycle", 32'(new_pc_valid), 32'd0);

        // pc + 1 wrap
        op(1, 0, 0, 20'hFFFFF, 20'h00003);
        op(0, 1, 0, '0, '0);
        check("wrap_new_pc", 32'(new_pc), 32'h00000);

        // Fill, overflow, recover, drain in LIFO order
        for (int k = 0; k < DEPTH; k++) begin
            op(1, 0, 0, ADDR_W'(k), ADDR_W'(k + 32'h100));
        end
        check("fill_full", 32'(full), 32'd1);
        op(1, 0, 0, 20'h00055, 20'h00777);
        check("ovf_flag", 32'(overflow_err), 32'd1);
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_no_strobe", 32'(new_pc_valid), 32'd0);
        check("ovf_count", 32'(count), 32'd16);
        op(0, 0, 1, '0, '0);
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 1, 0, '0, '0);
            check("drain_new_pc", 32'(new_pc), 32'(DEPTH - i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow, requests ignored in FAULT
        op(0, 1, 0, '0, '0);
        check("unf_flag", 32'(underflow_err), 32'd1);
        check("unf_no_strobe", 32'(new_pc_valid), 32'd0);
        op(1, 0, 0, 20'h00200, 20'h00300);
        check("fault_call_count", 32'(count), 32'd0);
        check("fault_call_no_strobe", 32'(new_pc_valid), 32'd0);
        op(0, 0, 1, '0, '0);

        // Protocol error with count = 3, then back-to-back CALL/RET
        op(1, 0, 0, 20'h00010, 20'h00A00);
        op(1, 0, 0, 20'h00020, 20'h00B00);
        op(1, 0, 0, 20'h00030, 20'h00C00);
        op(1, 1, 0, 20'h00040, 20'h00D00);
        check("proto_flag", 32'(proto_err), 32'd1);
        check("proto_count", 32'(count), 32'd3);
        check("proto_no_strobe", 32'(new_pc_valid), 32'd0);
        op(0, 0, 1, '0, '0);
        op(1, 0, 0, 20'h00040, 20'h00E00);
        op(0, 1, 0, '0, '0);
        check("b2b_ret_new_pc", 32'(new_pc), 32'h00041);

        // err_clr in RUN with a same-cycle request still processes it
        op(1, 0, 1, 20'h00050, 20'h00F00);
        check("clr_run_call", 32'(new_pc), 32'h00F00);
        check("clr_run_count", 32'(count), 32'd4);

        // Asynchronous reset with count = 5 and a strobe pending
        call_valid  = 1'b1;
        pc          = 20'h00060;
        call_target = 20'h01234;
        @(posedge clk);
        #1;
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_strobe", 32'(new_pc_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobe", 32'(new_pc_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_new_pc", 32'(new_pc), 32'd0);
        @(negedge clk);
        call_valid = 1'b0;
        rst_n      = 1'b1;
        op(0, 1, 0, '0, '0);
        check("post_rst_unf", 32'(underflow_err), 32'd1);
        op(0, 0, 1, '0, '0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ret_addr_stack
`default_nettype wire
